// File: rtl/iob_cache_fe_arbiter.sv
// iob_cache_fe_arbiter: shares one cache front-end port among N_REQ requesters, one transaction at a time.
// Define IOB_CACHE_FE_ARB_RR_EN for round-robin priority; default build uses fixed priority (lowest index wins).
module iob_cache_fe_arbiter #(
  parameter  int unsigned N_REQ  = 2,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          s_avalid_i,
  input  logic [N_REQ*ADDR_W-1:0]   s_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   s_wdata_i,
  input  logic [N_REQ*STRB_W-1:0]   s_wstrb_i,
  output logic [N_REQ-1:0]          s_ready_o,
  output logic [N_REQ-1:0]          s_rvalid_o,
  output logic [DATA_W-1:0]         s_rdata_o,
  output logic                      m_avalid_o,
  output logic [ADDR_W-1:0]         m_addr_o,
  output logic [DATA_W-1:0]         m_wdata_o,
  output logic [STRB_W-1:0]         m_wstrb_o,
  input  logic                      m_ready_i,
  input  logic                      m_rvalid_i,
  input  logic [DATA_W-1:0]         m_rdata_i,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_REQ-1:0]  winner;
  logic              own_avalid;
  logic              own_write;
  logic              accept;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic [STRB_W-1:0] own_wstrb;

  // AND-OR mux of the owner's request slice, chained over requesters
  logic [ADDR_W-1:0] addr_acc  [N_REQ+1];
  logic [DATA_W-1:0] wdata_acc [N_REQ+1];
  logic [STRB_W-1:0] wstrb_acc [N_REQ+1];

  assign addr_acc[0]  = '0;
  assign wdata_acc[0] = '0;
  assign wstrb_acc[0] = '0;

  for (genvar i = 0; i < N_REQ; i++) begin : g_mux
    assign addr_acc[i+1]  = addr_acc[i]  | (s_addr_i[i*ADDR_W +: ADDR_W]  & {ADDR_W{grant_o[i]}});
    assign wdata_acc[i+1] = wdata_acc[i] | (s_wdata_i[i*DATA_W +: DATA_W] & {DATA_W{grant_o[i]}});
    assign wstrb_acc[i+1] = wstrb_acc[i] | (s_wstrb_i[i*STRB_W +: STRB_W] & {STRB_W{grant_o[i]}});
  end

  assign own_addr   = addr_acc[N_REQ];
  assign own_wdata  = wdata_acc[N_REQ];
  assign own_wstrb  = wstrb_acc[N_REQ];
  assign own_avalid = |(s_avalid_i & grant_o);
  assign own_write  = |own_wstrb;
  assign accept     = (state == REQ) && own_avalid && m_ready_i;

`ifdef IOB_CACHE_FE_ARB_RR_EN
  // prio is one-hot on the highest-priority requester; search upward from it, then wrap
  logic [N_REQ-1:0] prio;
  logic [N_REQ-1:0] req_hi;
  logic [N_REQ-1:0] pick_hi;
  logic [N_REQ-1:0] pick_all;
  logic             done;

  assign req_hi   = s_avalid_i & ~(prio - N_REQ'(1));
  assign pick_hi  = req_hi & (~req_hi + N_REQ'(1));
  assign pick_all = s_avalid_i & (~s_avalid_i + N_REQ'(1));
  assign winner   = (|req_hi) ? pick_hi : pick_all;

  assign done = (accept && (own_write || m_rvalid_i)) ||
                ((state == WAIT_R) && m_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio <= N_REQ'(1);
    end else if (done) begin
      prio <= {grant_o[N_REQ-2:0], grant_o[N_REQ-1]};
    end
  end
`else
  assign winner = s_avalid_i & (~s_avalid_i + N_REQ'(1));
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|s_avalid_i) state_nxt = REQ;
      end
      REQ: begin
        if (!own_avalid) begin
          state_nxt = IDLE;
        end else if (m_ready_i) begin
          state_nxt = (own_write || m_rvalid_i) ? IDLE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_rvalid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner is latched on leaving IDLE and held until the transaction ends
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_o <= '0;
    end else if (state == IDLE) begin
      grant_o <= winner;
    end else if (state_nxt == IDLE) begin
      grant_o <= '0;
    end
  end

  // Output logic
  always_comb begin
    m_avalid_o = 1'b0;
    m_addr_o   = '0;
    m_wdata_o  = '0;
    m_wstrb_o  = '0;
    s_ready_o  = '0;
    s_rvalid_o = '0;
    case (state)
      REQ: begin
        m_avalid_o = own_avalid;
        m_addr_o   = own_addr;
        m_wdata_o  = own_wdata;
        m_wstrb_o  = own_wstrb;
        s_ready_o  = grant_o & {N_REQ{m_ready_i}};
        s_rvalid_o = grant_o & {N_REQ{accept && !own_write && m_rvalid_i}};
      end
      WAIT_R: begin
        s_rvalid_o = grant_o & {N_REQ{m_rvalid_i}};
      end
      default: ;
    endcase
  end

  assign s_rdata_o = m_rdata_i;
  assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
// Bench for iob_cache_fe_arbiter: directed vector table, reset corner case, and randomized run
// against a transaction-level model; follows IOB_CACHE_FE_ARB_RR_EN for the expected policy.
module tb_iob_cache_fe_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

`ifdef IOB_CACHE_FE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Owners that differ between round-robin and fixed priority
  localparam logic [2:0] G_A2 = RR ? 3'b010 : 3'b001;
  localparam logic [2:0] G_D2 = RR ? 3'b010 : 3'b001;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    s_avalid_i;
  logic [N*AW-1:0] s_addr_i;
  logic [N*DW-1:0] s_wdata_i;
  logic [N*SW-1:0] s_wstrb_i;
  logic [N-1:0]    s_ready_o;
  logic [N-1:0]    s_rvalid_o;
  logic [DW-1:0]   s_rdata_o;
  logic            m_avalid_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_wdata_o;
  logic [SW-1:0]   m_wstrb_o;
  logic            m_ready_i;
  logic            m_rvalid_i;
  logic [DW-1:0]   m_rdata_i;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  iob_cache_fe_arbiter #(
    .N_REQ (N),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .s_avalid_i(s_avalid_i),
    .s_addr_i  (s_addr_i),
    .s_wdata_i (s_wdata_i),
    .s_wstrb_i (s_wstrb_i),
    .s_ready_o (s_ready_o),
    .s_rvalid_o(s_rvalid_o),
    .s_rdata_o (s_rdata_o),
    .m_avalid_o(m_avalid_o),
    .m_addr_o  (m_addr_o),
    .m_wdata_o (m_wdata_o),
    .m_wstrb_o (m_wstrb_o),
    .m_ready_i (m_ready_i),
    .m_rvalid_i(m_rvalid_i),
    .m_rdata_i (m_rdata_i),
    .grant_o   (grant_o),
    .busy_o    (busy_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of directed stimulus and the outputs expected before the next edge
  typedef struct {
    logic [2:0]  av;
    logic        wr;
    logic        mrdy;
    logic        mrv;
    logic [31:0] rdata;
    logic [2:0]  g;
    logic        busy;
    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic        mav;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [2:0] av, input logic wr, input logic mrdy,
                             input logic mrv, input logic [31:0] rdata, input logic [2:0] g,
                             input logic busy, input logic [2:0] rdy, input logic [2:0] rv,
                             input logic mav);
    vec_t r;
    r.av = av; r.wr = wr; r.mrdy = mrdy; r.mrv = mrv; r.rdata = rdata;
    r.g = g; r.busy = busy; r.rdy = rdy; r.rv = rv; r.mav = mav;
    return r;
  endfunction

  // Transaction-level reference: owner index (-1 = none), read-data wait flag, priority start index
  int owner;
  bit waiting;
  int ptr;

  function automatic int pick(input logic [N-1:0] av, input int start);
    for (int i = 0; i < N; i++) begin
      if (av[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  logic [N-1:0]  e_grant, e_rdy, e_rv;
  logic          e_busy, e_mav;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_wstrb;
  logic [SW-1:0] o_wstrb;
  bit            in_req;

  initial begin
    rst_i      = 1'b1;
    s_avalid_i = '1;
    s_addr_i   = {16'h2222, 16'h1111, 16'h0abc};
    s_wdata_i  = {32'hcccc0002, 32'hcccc0001, 32'hcccc0000};
    s_wstrb_i  = '0;
    m_ready_i  = 1'b1;
    m_rvalid_i = 1'b1;
    m_rdata_i  = '0;

    // Reset dominates pending requests and front-end handshakes
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset grant",  64'(grant_o),    64'(0));
    chk("reset busy",   64'(busy_o),     64'(0));
    chk("reset mav",    64'(m_avalid_o), 64'(0));
    chk("reset rdy",    64'(s_ready_o),  64'(0));
    chk("reset rv",     64'(s_rvalid_o), 64'(0));
    chk("reset maddr",  64'(m_addr_o),   64'(0));
    rst_i      = 1'b0;
    s_avalid_i = '0;
    m_ready_i  = 1'b0;
    m_rvalid_i = 1'b0;

    // Three back-to-back reads from requesters 0 and 1
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b001, 1, 3'b000, 3'b000, 1));
    tbl.push_back(v(3'b011, 0, 1, 0, 32'h0,        3'b001, 1, 3'b001, 3'b000, 1));
    tbl.push_back(v(3'b011, 0, 0, 1, 32'hA5A5A5A5, 3'b001, 1, 3'b000, 3'b001, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        G_A2,   1, 3'b000, 3'b000, 1));
    tbl.push_back(v(3'b011, 0, 1, 0, 32'h0,        G_A2,   1, G_A2,   3'b000, 1));
    tbl.push_back(v(3'b011, 0, 0, 1, 32'h5A5A5A5A, G_A2,   1, 3'b000, G_A2,   0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b001, 1, 3'b000, 3'b000, 1));
    tbl.push_back(v(3'b011, 0, 1, 0, 32'h0,        3'b001, 1, 3'b001, 3'b000, 1));
    tbl.push_back(v(3'b011, 0, 0, 1, 32'h12345678, 3'b001, 1, 3'b000, 3'b001, 0));
    tbl.push_back(v(3'b000, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    // Write by requester 1 accepted on REQ entry; stray rvalid afterwards
    tbl.push_back(v(3'b010, 1, 1, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b010, 1, 1, 0, 32'h0,        3'b010, 1, 3'b010, 3'b000, 1));
    tbl.push_back(v(3'b000, 1, 0, 1, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    // Read with ready and rvalid together
    tbl.push_back(v(3'b001, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b001, 0, 1, 1, 32'hC3C3C3C3, 3'b001, 1, 3'b001, 3'b001, 1));
    tbl.push_back(v(3'b000, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    // Owner drops its request; others toggle; priority must not advance
    tbl.push_back(v(3'b010, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b110, 0, 0, 0, 32'h0,        3'b010, 1, 3'b000, 3'b000, 1));
    tbl.push_back(v(3'b000, 0, 0, 0, 32'h0,        3'b010, 1, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b011, 0, 0, 0, 32'h0,        G_D2,   1, 3'b000, 3'b000, 1));
    tbl.push_back(v(3'b000, 0, 0, 0, 32'h0,        G_D2,   1, 3'b000, 3'b000, 0));
    tbl.push_back(v(3'b000, 0, 0, 0, 32'h0,        3'b000, 0, 3'b000, 3'b000, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      s_avalid_i = tbl[i].av;
      s_wstrb_i  = tbl[i].wr ? '1 : '0;
      m_ready_i  = tbl[i].mrdy;
      m_rvalid_i = tbl[i].mrv;
      m_rdata_i  = tbl[i].rdata;
      #1;
      chk($sformatf("row%0d grant", i), 64'(grant_o),    64'(tbl[i].g));
      chk($sformatf("row%0d busy", i),  64'(busy_o),     64'(tbl[i].busy));
      chk($sformatf("row%0d rdy", i),   64'(s_ready_o),  64'(tbl[i].rdy));
      chk($sformatf("row%0d rv", i),    64'(s_rvalid_o), 64'(tbl[i].rv));
      chk($sformatf("row%0d mav", i),   64'(m_avalid_o), 64'(tbl[i].mav));
      chk($sformatf("row%0d rdata", i), 64'(s_rdata_o),  64'(tbl[i].rdata));
    end

    // Reset while waiting for read data, then late rvalid must be ignored
    @(negedge clk);
    s_avalid_i = 3'b001; s_wstrb_i = '0; m_ready_i = 1'b0; m_rvalid_i = 1'b0;
    @(negedge clk);
    m_ready_i = 1'b1;
    #1 chk("wr_rst accept rdy", 64'(s_ready_o), 64'(3'b001));
    @(negedge clk);
    m_ready_i = 1'b0; s_avalid_i = '0;
    #1 chk("wr_rst in WAIT_R busy", 64'(busy_o), 64'(1));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
    #1;
    chk("wr_rst late rv",   64'(s_rvalid_o), 64'(0));
    chk("wr_rst grant",     64'(grant_o),    64'(0));
    chk("wr_rst busy",      64'(busy_o),     64'(0));
    @(negedge clk);
    m_rvalid_i = 1'b0;
    #1 chk("wr_rst idle busy", 64'(busy_o), 64'(0));

    // Randomized run against the reference model
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    owner = -1; waiting = 1'b0; ptr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst_i = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < N; k++) begin
        s_avalid_i[k]           = ($urandom_range(0, 3) != 0);
        s_addr_i[k*AW +: AW]    = AW'($urandom);
        s_wdata_i[k*DW +: DW]   = $urandom;
        s_wstrb_i[k*SW +: SW]   = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
      end
      m_ready_i  = ($urandom_range(0, 1) == 1);
      m_rvalid_i = ($urandom_range(0, 2) == 0);
      m_rdata_i  = $urandom;
      #1;
      e_grant = '0; e_rdy = '0; e_rv = '0; e_mav = 1'b0;
      e_addr = '0; e_wdata = '0; e_wstrb = '0; o_wstrb = '0;
      e_busy = (owner >= 0);
      in_req = (owner >= 0) && !waiting;
      if (owner >= 0) begin
        e_grant = N'(1) << owner;
        o_wstrb = s_wstrb_i[owner*SW +: SW];
      end
      if (in_req) begin
        e_mav   = s_avalid_i[owner];
        e_addr  = s_addr_i[owner*AW +: AW];
        e_wdata = s_wdata_i[owner*DW +: DW];
        e_wstrb = o_wstrb;
        if (m_ready_i) e_rdy = e_grant;
        if (e_mav && m_ready_i && o_wstrb == '0 && m_rvalid_i) e_rv = e_grant;
      end else if (waiting && m_rvalid_i) begin
        e_rv = e_grant;
      end
      chk("rnd grant", 64'(grant_o),    64'(e_grant));
      chk("rnd busy",  64'(busy_o),     64'(e_busy));
      chk("rnd rdy",   64'(s_ready_o),  64'(e_rdy));
      chk("rnd rv",    64'(s_rvalid_o), 64'(e_rv));
      chk("rnd mav",   64'(m_avalid_o), 64'(e_mav));
      chk("rnd addr",  64'(m_addr_o),   64'(e_addr));
      chk("rnd wdata", 64'(m_wdata_o),  64'(e_wdata));
      chk("rnd wstrb", 64'(m_wstrb_o),  64'(e_wstrb));
      chk("rnd rdata", 64'(s_rdata_o),  64'(m_rdata_i));
      // Advance the model across the coming edge
      if (rst_i) begin
        owner = -1; waiting = 1'b0; ptr = 0;
      end else if (owner < 0) begin
        owner = pick(s_avalid_i, RR ? ptr : 0);
      end else if (!waiting) begin
        if (!s_avalid_i[owner]) begin
          owner = -1;
        end else if (m_ready_i) begin
          if (o_wstrb != '0 || m_rvalid_i) begin
            if (RR) ptr = (owner + 1) % N;
            owner = -1;
          end else begin
            waiting = 1'b1;
          end
        end
      end else if (m_rvalid_i) begin
        if (RR) ptr = (owner + 1) % N;
        owner = -1; waiting = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
